// File: rtl/scan_ctrl_7seg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : scan_ctrl_7seg                                             |
// | Description : 4-digit common-anode 7-segment scan controller with        |
// |               per-slot PWM dimming, leading-zero blanking and a          |
// |               double-buffered valid/ready write port.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module scan_ctrl_7seg #(
  parameter int TICK_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        blank_lz,
  input  logic [3:0]  brightness,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        frame_done
);

  // The slot counter is split into a sub-phase counter and a 4-bit PWM phase
  // so that phase = cnt/SUB never needs a real divider (SUB need not be 2^n).
  localparam int SUB = TICK_DIV / 16;
  localparam int SW  = $clog2(SUB);
  localparam logic [SW-1:0] SUB_LAST = SW'(SUB - 1);

  logic [SW-1:0] sub_q;
  logic [3:0]    phase_q;
  logic [1:0]    digit_q;
  logic [3:0]    bright_q;
  logic [15:0]   active_q;
  logic [15:0]   pend_q;
  logic          pend_full_q;
  logic [3:0]    anode_q;
  logic [6:0]    seg_q;
  logic          frame_done_q;

  logic          slot_start;
  logic          boundary;
  logic          xfer;
  logic [3:0]    nib;
  logic          blank;
  logic          lit;
  logic [3:0]    anode_d;
  logic [6:0]    seg_d;

  assign wr_ready   = ~pend_full_q;
  assign anode      = anode_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

  // Slot/frame position decode, transfer condition and digit selection.
  always_comb begin
    slot_start = (sub_q == '0) && (phase_q == 4'h0);
    boundary   = enable && (sub_q == SUB_LAST) && (phase_q == 4'hF) && (digit_q == 2'd3);
    xfer       = pend_full_q && (!enable || boundary);
    nib        = 4'h0;
    blank      = 1'b0;
    case (digit_q)
      2'd0: begin nib = active_q[3:0];   blank = 1'b0;                    end
      2'd1: begin nib = active_q[7:4];   blank = (active_q[15:4]  == '0); end
      2'd2: begin nib = active_q[11:8];  blank = (active_q[15:8]  == '0); end
      default: begin nib = active_q[15:12]; blank = (active_q[15:12] == '0); end
    endcase
    blank = blank && blank_lz;
    lit   = enable && !blank && (phase_q <= bright_q);
  end

  // Active-low segment decode with 'E' for non-BCD codes, then lit gating.
  always_comb begin
    case (nib)
      4'd0:    seg_d = 7'b0000001;
      4'd1:    seg_d = 7'b1001111;
      4'd2:    seg_d = 7'b0010010;
      4'd3:    seg_d = 7'b0000110;
      4'd4:    seg_d = 7'b1001100;
      4'd5:    seg_d = 7'b0100100;
      4'd6:    seg_d = 7'b0100000;
      4'd7:    seg_d = 7'b0001111;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0000100;
      default: seg_d = 7'b0110000;
    endcase
    anode_d = ~(4'b0001 << digit_q);
    if (!lit) begin
      seg_d   = 7'b1111111;
      anode_d = 4'b1111;
    end
  end

  // Scan position: held at slot 0/digit 0 while disabled, else free-running.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sub_q    <= '0;
      phase_q  <= 4'h0;
      digit_q  <= 2'd0;
      bright_q <= 4'h0;
    end else begin
      if (!enable) begin
        sub_q   <= '0;
        phase_q <= 4'h0;
        digit_q <= 2'd0;
      end else if (sub_q == SUB_LAST) begin
        sub_q   <= '0;
        phase_q <= phase_q + 4'd1;
        if (phase_q == 4'hF) begin
          digit_q <= digit_q + 2'd1;
        end
      end else begin
        sub_q <= sub_q + SW'(1);
      end
      if (enable && slot_start) begin
        bright_q <= brightness;
      end
    end
  end

  // Double buffer: accept into pending, move to active at frame boundary.
  always_ff @(posedge clk) begin
    if (!reset) begin
      active_q    <= 16'h0000;
      pend_q      <= 16'h0000;
      pend_full_q <= 1'b0;
    end else if (xfer) begin
      active_q    <= pend_q;
      pend_full_q <= 1'b0;
    end else if (wr_valid && !pend_full_q) begin
      pend_q      <= wr_data;
      pend_full_q <= 1'b1;
    end
  end

  // Registered display outputs and frame pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      anode_q      <= 4'b1111;
      seg_q        <= 7'b1111111;
      frame_done_q <= 1'b0;
    end else begin
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      frame_done_q <= boundary;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scan_ctrl_7seg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_scan_ctrl_7seg                                          |
// | Description : Self-checking bench for scan_ctrl_7seg against a           |
// |               frame-position reference model.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_scan_ctrl_7seg;

  localparam int TD  = 32;
  localparam int SUBM = TD / 16;
  localparam int FRAME = 4 * TD;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  brightness = 4'h0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic        wr_ready;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        frame_done;

  scan_ctrl_7seg #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .anode      (anode),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int fd_seen = 0;

  // Reference model state: position in frame as a plain cycle count.
  int          m_t;
  int          m_bright;
  int          m_active;
  int          m_pend;
  bit          m_full;
  bit          m_init = 1'b0;
  bit          m_acc;
  logic [3:0]  e_anode;
  logic [6:0]  e_seg;
  logic        e_fd;
  logic [6:0]  seg_tab [16];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock with the given inputs (pre-edge state).
  task automatic model_step(input logic rn, en, blz, input logic [3:0] br,
                            input logic wv, input logic [15:0] wd);
    int slot, d, ph, nib;
    bit blank, lit, bnd, xf;
    m_acc = 1'b0;
    if (!rn) begin
      m_t = 0; m_bright = 0; m_active = 0; m_pend = 0; m_full = 1'b0;
      e_anode = 4'hF; e_seg = 7'h7F; e_fd = 1'b0;
      m_init = 1'b1;
      return;
    end
    bnd = 1'b0;
    if (!en) begin
      e_anode = 4'hF; e_seg = 7'h7F; e_fd = 1'b0;
      m_t = 0;
    end else begin
      slot  = m_t % TD;
      d     = m_t / TD;
      ph    = slot / SUBM;
      nib   = (m_active >> (4 * d)) & 15;
      blank = blz && (d > 0) && ((m_active >> (4 * d)) == 0);
      lit   = !blank && (ph <= m_bright);
      e_anode = lit ? ~(4'b0001 << d) : 4'hF;
      e_seg   = lit ? seg_tab[nib] : 7'h7F;
      bnd     = (m_t == FRAME - 1);
      e_fd    = bnd;
      if (slot == 0) m_bright = int'(br);
      m_t = (m_t + 1) % FRAME;
    end
    xf = m_full && (!en || bnd);
    if (xf) begin
      m_active = m_pend;
      m_full   = 1'b0;
    end else if (wv && !m_full) begin
      m_pend = int'(wd);
      m_full = 1'b1;
      m_acc  = 1'b1;
    end
  endtask

  // One clock: drive on negedge, check ready, predict, compare after posedge.
  task automatic cycle(input logic rn, en, blz, input logic [3:0] br,
                       input logic wv, input logic [15:0] wd);
    @(negedge clk);
    reset = rn; enable = en; blank_lz = blz; brightness = br;
    wr_valid = wv; wr_data = wd;
    #1;
    if (m_init) check("wr_ready_pre", {15'd0, wr_ready}, {15'd0, !m_full});
    model_step(rn, en, blz, br, wv, wd);
    @(posedge clk);
    #1;
    check("anode", {12'd0, anode}, {12'd0, e_anode});
    check("seg", {9'd0, seg}, {9'd0, e_seg});
    check("frame_done", {15'd0, frame_done}, {15'd0, e_fd});
    check("wr_ready", {15'd0, wr_ready}, {15'd0, !m_full});
    if (frame_done === 1'b1) fd_seen++;
  endtask

  task automatic run(input int n, input logic en, blz, input logic [3:0] br);
    for (int i = 0; i < n; i++) cycle(1'b1, en, blz, br, 1'b0, 16'h0000);
  endtask

  // Load a value straight into active via the disabled-transfer path.
  task automatic load(input logic [15:0] v, input logic blz, input logic [3:0] br);
    cycle(1'b1, 1'b0, blz, br, 1'b1, v);
    run(2, 1'b0, blz, br);
  endtask

  initial begin
    logic [3:0] r_br;
    logic       r_en, r_blz, got;
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
    seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0000100;
    for (int k = 10; k < 16; k++) seg_tab[k] = 7'b0110000;

    // Reset and idle
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0);
    run(4, 1'b0, 1'b0, 4'h0);

    // Write 1234 with scanning at full brightness; count frame pulses
    cycle(1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 16'h1234);
    fd_seen = 0;
    run(FRAME * 3 - 1, 1'b1, 1'b0, 4'hF);
    check("fd_count_3frames", 16'(fd_seen), 16'd3);

    // PWM: level 3, then drop to 0 mid-slot
    run(FRAME + 10, 1'b1, 1'b0, 4'h3);
    run(FRAME, 1'b1, 1'b0, 4'h0);

    // Leading-zero blanking
    load(16'h0070, 1'b1, 4'hF);
    run(FRAME + 5, 1'b1, 1'b1, 4'hF);
    load(16'h0000, 1'b1, 4'hF);
    run(FRAME + 5, 1'b1, 1'b1, 4'hF);

    // Handshake around the boundary: A mid-frame, B held until accepted
    run(40, 1'b1, 1'b0, 4'hF);
    cycle(1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 16'h5678);
    got = 1'b0;
    for (int i = 0; i < 3 * FRAME && !got; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 16'h9012);
      got = m_acc;
    end
    check("hs_b_accepted", {15'd0, got}, 16'd1);
    run(2 * FRAME + 3, 1'b1, 1'b0, 4'hF);

    // Invalid BCD, then disable with a write while dark
    load(16'h00F0, 1'b1, 4'hF);
    run(FRAME + 2, 1'b1, 1'b1, 4'hF);
    cycle(1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 16'h4321);
    run(3, 1'b0, 1'b1, 4'hF);
    run(FRAME, 1'b1, 1'b0, 4'hF);

    // Randomized traffic
    r_en = 1'b1; r_blz = 1'b0; r_br = 4'hF;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 399) == 0) r_en = ~r_en;
      if ($urandom_range(0, 299) == 0) r_blz = ~r_blz;
      if ($urandom_range(0, 63) == 0)  r_br = 4'($urandom_range(0, 15));
      cycle(($urandom_range(0, 2999) == 0) ? 1'b0 : 1'b1, r_en, r_blz, r_br,
            ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
            16'($urandom) >> $urandom_range(0, 12));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scan_ctrl_7seg.md
Name: scan_ctrl_7seg

Overview:
Scan controller for the 4-digit common-anode 7-segment display on the board. It time-multiplexes four BCD digits onto anode/seg and applies per-digit PWM dimming and optional leading-zero blanking. New display values arrive over a valid/ready write port and are double-buffered, so each refresh frame shows one consistent value. It replaces the free-running counter, mux and demux scan chain in display tops.

Parameters:
TICK_DIV, 50000, clk cycles per digit slot; must be a multiple of 16 and at least 32
SUB, TICK_DIV/16, derived local constant: clk cycles per PWM sub-phase

Ports:
clk  in  1  system clock (100 MHz on board)
reset  in  1  synchronous, active-low reset (0 = reset)
enable  in  1  1 = scanning; 0 = display dark
blank_lz  in  1  1 = blank leading zeros
brightness  in  4  PWM level; 0 = 1/16 duty, 15 = full duty
wr_valid  in  1  write request
wr_data  in  16  four BCD digits; [3:0] = digit0 (anode[0], rightmost), [15:12] = digit3
wr_ready  out  1  write port can accept
anode  out  4  active-low digit enables
seg  out  7  active-low segments, {a,b,c,d,e,f,g} = seg[6:0]
frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (reset=0 at posedge clk):
  - anode=4'b1111, seg=7'b1111111, frame_done=0.
  - active register=16'h0000; pending buffer empty (so wr_ready=1).
  - Prescaler, digit index and latched brightness all =0.
- Prescaler cnt runs 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and the digit index advances 0→1→2→3→0.
- Frame boundary: cnt==TICK_DIV-1 with digit index 3. frame_done=1 in the following cycle only.
- Brightness is latched at cnt==0 of every slot. A mid-slot change takes effect next slot.
- PWM: phase = cnt/SUB (0..15). The selected digit is lit while phase <= latched brightness; otherwise anode=1111 and seg=1111111.
- Segment decode (active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - 10..15 show 'E' = 0110000.
- Leading-zero blanking (blank_lz=1, evaluated on the active register):
  - digit3 is blank if d3==0.
  - digit2 is blank if d3==0 and d2==0.
  - digit1 is blank if d3, d2 and d1 are all 0.
  - digit0 is never blanked.
  - A blank digit gives anode=1111 and seg=1111111 for the whole slot.
  - An invalid-BCD digit is not zero, so it is not blanked.
- anode and seg are registered: they reflect the cnt, digit index and active value of the previous cycle (1-cycle latency). Exactly one anode bit is low when lit, e.g. digit k gives anode=~(1<<k).
- Write port:
  - wr_ready = ~pending_full (combinational from the flag).
  - wr_valid & wr_ready stores wr_data into pending and sets pending_full.
  - wr_data is ignored when wr_ready=0; the source must hold it.
- Transfer from pending to active (pending_full then clears, wr_ready=1 the next cycle):
  - enable=1: only at a frame boundary with pending_full=1.
  - enable=0: the cycle after pending_full is seen.
- Simultaneous events:
  - A write accepted in the boundary cycle with pending empty lands in pending only; it transfers at the next boundary.
  - A write presented in the boundary cycle with pending full is not accepted (wr_ready=0). It is accepted the cycle after the transfer.
- enable=0:
  - anode=1111, seg=1111111, frame_done=0.
  - cnt and digit index are held at 0.
  - On enable rising, scanning starts at digit0, cnt=0.
- Reset mid-operation: returns everything to reset values on that edge. Any pending data is discarded.
- No combinational path from wr_valid to wr_ready.

Test Plan:
1. Reset/idle: TICK_DIV=32, hold reset=0 for 3 clk, then enable=0 → anode=1111, seg=1111111, wr_ready=1, frame_done=0.
2. Write and scan: write 16'h1234, enable=1, brightness=15, blank_lz=0.
   - Active updates at the first boundary; frame_done pulses once per 128 clk.
   - Next frame: anode=1110/seg=0011001? no, digit0=4 gives seg=1001100; digit1=3 gives 0000110; digit2=2 gives 0010010; digit3=1 gives 1001111.
   - Each digit is lit for all 32 clk of its slot.
3. PWM: brightness=3 → each digit lit for 8 clk (phases 0..3) then dark for 24 clk. Change brightness to 0 mid-slot → the current slot is unchanged; the next slot is lit for 2 clk.
4. Leading-zero blanking: active=16'h0070, blank_lz=1 → digit3 and digit2 are dark for the whole slot; digit1 shows 0001111; digit0 shows 0000001. Active=16'h0000 → only digit0 is lit, showing 0000001.
5. Handshake at the boundary:
   - Write A mid-frame → wr_ready=0.
   - Hold wr_valid with B → B is not accepted until the cycle after the boundary transfer of A.
   - The display shows A for the next full frame and B from the frame after.
6. Invalid BCD and disable: active=16'h00F0 → digit1 shows seg=0110000 and is not blanked. Then drop enable: outputs go dark next cycle, and a write issued while disabled reaches active within 2 clk.
